riscv_dcache_fsm: RTL

- Miss/write-back controller that sequences the direct-mapped data-cache tag array and data array.
- Decodes CPU load/store requests against the tag array's hit/dirty flags and stalls the pipeline on a miss.
- On a dirty miss, evicts the victim line to memory beat by beat, then refills the line from memory, then rewrites the tag entry.
- Sits between the CPU memory stage, the tag/data arrays (which write on negedge clk) and the external memory/bus interface.

---
 rtl/riscv_dcache_fsm.sv | 126 ++++++++++++
 1 files changed

// File: rtl/riscv_dcache_fsm.sv
// Data-cache miss/write-back controller: decodes CPU requests against the tag array,
// evicts dirty victims, refills the line beat by beat and rewrites the tag entry.
module riscv_dcache_fsm #(
    parameter int unsigned BEATS = 4,
    parameter int unsigned CW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_rden,
    input  logic          cpu_wren,
    input  logic          hit,
    input  logic          dirty,
    input  logic          mem_ready,
    output logic          stall,
    output logic          tag_replace,
    output logic          tag_valid_in,
    output logic          tag_dirty_in,
    output logic          cache_wren,
    output logic          refill_wren,
    output logic [CW-1:0] beat_idx,
    output logic          mem_rden,
    output logic          mem_wren,
    output logic          addr_sel
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WRITE_BACK = 2'd1;
    localparam logic [1:0] ALLOCATE   = 2'd2;
    localparam logic [1:0] UPDATE     = 2'd3;

    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req;

    assign req = cpu_rden | cpu_wren;

    // State and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode; outputs are forced low while reset is held
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall        = 1'b0;
        tag_replace  = 1'b0;
        tag_valid_in = 1'b0;
        tag_dirty_in = 1'b0;
        cache_wren   = 1'b0;
        refill_wren  = 1'b0;
        beat_idx     = cnt_q;
        mem_rden     = 1'b0;
        mem_wren     = 1'b0;
        addr_sel     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (cpu_wren) begin
                            cache_wren   = 1'b1;
                            tag_replace  = 1'b1;
                            tag_valid_in = 1'b1;
                            tag_dirty_in = 1'b1;
                        end
                    end else begin
                        stall   = 1'b1;
                        cnt_d   = '0;
                        state_d = dirty ? WRITE_BACK : ALLOCATE;
                    end
                end
            end
            WRITE_BACK: begin
                stall    = 1'b1;
                mem_wren = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ALLOCATE;
                    end
                end
            end
            ALLOCATE: begin
                stall       = 1'b1;
                mem_rden    = 1'b1;
                refill_wren = mem_ready;
                if (mem_ready) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = UPDATE;
                    end
                end
            end
            default: begin
                stall        = 1'b1;
                tag_replace  = 1'b1;
                tag_valid_in = 1'b1;
                state_d      = IDLE;
            end
        endcase

        if (!rst_n) begin
            stall        = 1'b0;
            tag_replace  = 1'b0;
            tag_valid_in = 1'b0;
            tag_dirty_in = 1'b0;
            cache_wren   = 1'b0;
            refill_wren  = 1'b0;
            beat_idx     = '0;
            mem_rden     = 1'b0;
            mem_wren     = 1'b0;
            addr_sel     = 1'b0;
        end
    end

endmodule
